apb_bus_controller: RTL and testbench

- APB master and arbiter that shares the APB bus between two on-chip requesters and sequences SETUP/ACCESS phases toward the two APB slaves on the bus.
- Decodes a byte address: bit 7 selects slave 1 (0) or slave 2 (1); bits 6:0 drive PADDR.
- Captures a request, runs one APB transfer, returns read data and error status to the granted requester.
- Uses round-robin arbitration and a PREADY timeout.

---
 rtl/apb_bus_controller.sv | 183 ++++++++++++++++++
 tb/tb_apb_bus_controller.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_controller.sv
// Two-requester APB master: round-robin arbiter feeding a SETUP/ACCESS sequencer,
// with a PREADY timeout that turns a hung slave into an error completion.
module apb_bus_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req0,
  input  logic       req1,
  input  logic       wr0,
  input  logic       wr1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       grant0,
  output logic       grant1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       PSELECT1,
  output logic       PSELECT2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [6:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2,
  input  logic       PREADY1,
  input  logic       PREADY2,
  input  logic       PSLVERR1,
  input  logic       PSLVERR2
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             own_q, own_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             grant0_q, grant0_d, grant1_q, grant1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             psel1_q, psel1_d, psel2_q, psel2_d;
  logic             pen_q, pen_d;
  logic             pwrite_q, pwrite_d;
  logic [6:0]       paddr_q, paddr_d;
  logic [7:0]       pwdata_q, pwdata_d;

  logic             win;
  logic [7:0]       sel_addr;
  logic             sel_ready, sel_slverr;
  logic [7:0]       sel_prdata;

  // Both requesting: the one that did not win last time goes next.
  assign win      = req0 ? (req1 ? ~last_q : 1'b0) : 1'b1;
  assign sel_addr = win ? addr1 : addr0;

  // Only the selected slave's response is observed.
  assign sel_ready  = psel2_q ? PREADY2  : PREADY1;
  assign sel_slverr = psel2_q ? PSLVERR2 : PSLVERR1;
  assign sel_prdata = psel2_q ? PRDATA2  : PRDATA1;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    own_d    = own_q;
    cnt_d    = cnt_q;
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    psel1_d  = psel1_q;
    psel2_d  = psel2_q;
    pen_d    = pen_q;
    pwrite_d = pwrite_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          last_d   = win;
          own_d    = win;
          grant0_d = ~win;
          grant1_d = win;
          pwrite_d = win ? wr1 : wr0;
          pwdata_d = win ? wdata1 : wdata0;
          paddr_d  = sel_addr[6:0];
          psel1_d  = ~sel_addr[7];
          psel2_d  = sel_addr[7];
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        pen_d   = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          psel1_d = 1'b0;
          psel2_d = 1'b0;
          pen_d   = 1'b0;
          done0_d = ~own_q;
          done1_d = own_q;
          rdata_d = pwrite_q ? 8'h00 : sel_prdata;
          err_d   = sel_slverr;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            psel1_d = 1'b0;
            psel2_d = 1'b0;
            pen_d   = 1'b0;
            done0_d = ~own_q;
            done1_d = own_q;
            rdata_d = 8'h00;
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      own_q    <= 1'b0;
      cnt_q    <= '0;
      grant0_q <= 1'b0;
      grant1_q <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata_q  <= 8'h00;
      err_q    <= 1'b0;
      psel1_q  <= 1'b0;
      psel2_q  <= 1'b0;
      pen_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= 7'h00;
      pwdata_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      own_q    <= own_d;
      cnt_q    <= cnt_d;
      grant0_q <= grant0_d;
      grant1_q <= grant1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      psel1_q  <= psel1_d;
      psel2_q  <= psel2_d;
      pen_q    <= pen_d;
      pwrite_q <= pwrite_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end

  assign grant0   = grant0_q;
  assign grant1   = grant1_q;
  assign done0    = done0_q;
  assign done1    = done1_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign PSELECT1 = psel1_q;
  assign PSELECT2 = psel2_q;
  assign PENABLE  = pen_q;
  assign PWRITE   = pwrite_q;
  assign PADDR    = paddr_q;
  assign PWDATA   = pwdata_q;

endmodule

// File: tb/tb_apb_bus_controller.sv
// Directed bench: two byte-array APB slaves with programmable wait/stuck/error,
// scoreboard of expected completions popped on each done pulse.
module tb_apb_bus_controller;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       req0, req1, wr0, wr1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       grant0, grant1, done0, done1, err;
  logic [7:0] rdata;
  logic       PSELECT1, PSELECT2, PENABLE, PWRITE;
  logic [6:0] PADDR;
  logic [7:0] PWDATA, PRDATA1, PRDATA2;
  logic       PREADY1, PREADY2, PSLVERR1, PSLVERR2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         r;
    logic [7:0] rd;
    logic       er;
    int         pen;
  } exp_t;
  exp_t sb[$];

  // slave model
  logic [7:0] mem1 [0:127];
  logic [7:0] mem2 [0:127];
  int   wait_n = 0;
  logic stuck  = 1'b0;
  logic slverr = 1'b0;
  int   acc_cnt;

  always #5 PCLK = ~PCLK;

  apb_bus_controller #(.TIMEOUT(16), .CNT_W(5)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .rdata(rdata), .err(err),
    .PSELECT1(PSELECT1), .PSELECT2(PSELECT2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2),
    .PREADY1(PREADY1), .PREADY2(PREADY2), .PSLVERR1(PSLVERR1), .PSLVERR2(PSLVERR2)
  );

  always @(posedge PCLK or posedge PRESET)
    if (PRESET) acc_cnt <= 0;
    else        acc_cnt <= PENABLE ? acc_cnt + 1 : 0;

  assign PREADY1  = PSELECT1 && PENABLE && !stuck && (acc_cnt >= wait_n);
  assign PREADY2  = PSELECT2 && PENABLE && !stuck && (acc_cnt >= wait_n);
  assign PSLVERR1 = PREADY1 && slverr;
  assign PSLVERR2 = PREADY2 && slverr;
  assign PRDATA1  = mem1[PADDR];
  assign PRDATA2  = mem2[PADDR];

  always @(posedge PCLK) begin
    if (PSELECT1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR] <= PWDATA;
    if (PSELECT2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR] <= PWDATA;
  end

  always @(negedge PCLK)
    if (!PRESET)
      assert (!(PSELECT1 && PSELECT2) && !(done0 && done1) && !(grant0 && grant1))
      else begin
        n_err++;
        $error("FAIL onehot: sel=%b%b done=%b%b grant=%b%b expected at most one each",
               PSELECT2, PSELECT1, done1, done0, grant1, grant0);
      end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic v, input logic w,
                       input logic [7:0] a, input logic [7:0] d);
    if (r == 0) begin req0 = v; wr0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = v; wr1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic do_reset();
    @(negedge PCLK); PRESET = 1'b1;
    @(negedge PCLK); PRESET = 1'b0;
  endtask

  // One full transfer; expectations pushed on issue, popped at done.
  task automatic xfer(input int r, input logic w, input logic [7:0] a, input logic [7:0] d,
                      input logic [7:0] rd_exp, input logic er_exp, input int pen_exp);
    exp_t e;
    int   pen;
    @(negedge PCLK);
    drive(r, 1'b1, w, a, d);
    e = '{r: r, rd: rd_exp, er: er_exp, pen: pen_exp};
    sb.push_back(e);
    for (int k = 0; k < 8; k++) begin
      @(negedge PCLK);
      if (grant0 || grant1) break;
    end
    chk("grant", {grant1, grant0}, (r == 1) ? 2'b10 : 2'b01);
    chk("setup_sel", {PSELECT2, PSELECT1, PENABLE}, {a[7], ~a[7], 1'b0});
    chk("setup_paddr", PADDR, a[6:0]);
    chk("setup_pwrite", PWRITE, w);
    if (w) chk("setup_pwdata", PWDATA, d);
    drive(r, 1'b0, w, a, d);
    pen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge PCLK);
      if (done0 || done1) break;
      if (PENABLE) pen++;
    end
    e = sb.pop_front();
    chk("done", {done1, done0}, (e.r == 1) ? 2'b10 : 2'b01);
    chk("rdata", rdata, e.rd);
    chk("err", err, e.er);
    chk("penable_cycles", pen, e.pen);
    chk("done_idle_sel", {PSELECT2, PSELECT1, PENABLE}, 3'b000);
    @(negedge PCLK);
    chk("done_pulse", {done1, done0}, 2'b00);
    chk("rdata_hold", rdata, e.rd);
  endtask

  initial begin
    int   gcyc [$];
    int   gid  [$];
    exp_t e;
    PRESET = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    #12;
    chk("reset_outs", {grant0, grant1, done0, done1, rdata, err, PSELECT1, PSELECT2,
                       PENABLE, PWRITE, PADDR, PWDATA}, 32'h0);
    @(negedge PCLK); PRESET = 1'b0;

    // slave 1 write/read, slave 2 decode
    xfer(0, 1'b1, 8'h05, 8'hA5, 8'h00, 1'b0, 1);
    xfer(0, 1'b0, 8'h05, 8'h00, 8'hA5, 1'b0, 1);
    xfer(1, 1'b1, 8'h85, 8'h3C, 8'h00, 1'b0, 1);
    xfer(1, 1'b0, 8'h85, 8'h00, 8'h3C, 1'b0, 1);
    xfer(0, 1'b0, 8'h05, 8'h00, 8'hA5, 1'b0, 1);

    // wait states
    wait_n = 3;
    xfer(0, 1'b0, 8'h85, 8'h00, 8'h3C, 1'b0, 4);
    wait_n = 0;

    // timeout and slave error
    stuck = 1'b1;
    xfer(1, 1'b0, 8'h05, 8'h00, 8'h00, 1'b1, 16);
    stuck = 1'b0;
    slverr = 1'b1;
    xfer(0, 1'b1, 8'h10, 8'h77, 8'h00, 1'b1, 1);
    slverr = 1'b0;

    // simultaneous requests from reset: 0,1,0,1 every 3 cycles
    do_reset();
    drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h85, 8'h00);
    for (int c = 1; c <= 12; c++) begin
      @(negedge PCLK);
      if (grant0 || grant1) begin
        gcyc.push_back(c);
        gid.push_back(grant1 ? 1 : 0);
        e = '{r: grant1 ? 1 : 0, rd: grant1 ? 8'h3C : 8'hA5, er: 1'b0, pen: 1};
        sb.push_back(e);
      end
      if (done0 || done1) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("arb_done", {done1, done0}, (e.r == 1) ? 2'b10 : 2'b01);
          chk("arb_rdata", rdata, e.rd);
        end else chk("arb_done_unexpected", {done1, done0}, 2'b00);
      end
      if (c == 12) begin req0 = 1'b0; req1 = 1'b0; end
    end
    chk("arb_ngrants", gcyc.size(), 4);
    for (int i = 0; i < 4 && i < gcyc.size(); i++) begin
      chk("arb_order", gid[i], i % 2);
      chk("arb_cycle", gcyc[i], 1 + 3 * i);
    end
    chk("arb_sb_empty", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge PCLK);

    // reset mid-ACCESS, then tie goes to requester 0
    stuck = 1'b1;
    @(negedge PCLK);
    drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
    for (int k = 0; k < 8; k++) begin
      @(negedge PCLK);
      if (grant0) req0 = 1'b0;
      if (PENABLE) break;
    end
    chk("pre_reset_access", {PENABLE, PSELECT1}, 2'b11);
    #2 PRESET = 1'b1;
    #1;
    chk("reset_mid", {PSELECT1, PSELECT2, PENABLE, done0, done1, err}, 6'b0);
    req0 = 1'b0; stuck = 1'b0;
    @(negedge PCLK);
    chk("reset_held", {PSELECT1, PENABLE, done0, done1}, 4'b0);
    PRESET = 1'b0;
    drive(0, 1'b1, 1'b0, 8'h05, 8'h00);
    drive(1, 1'b1, 1'b0, 8'h85, 8'h00);
    @(negedge PCLK);
    chk("post_reset_grant", {grant1, grant0}, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    repeat (4) @(negedge PCLK);
    chk("post_reset_done_err", err, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule
